// File: rtl/predecode_int_ctrl_if.sv
// Opcode/interrupt handshake between the bus pins, the predecode stage and the control FSM.
// The master drives the pins and reads back the registered opcode and interrupt selection.
interface predecode_int_ctrl_if;
  logic       RDY;
  logic       T1now;
  logic [7:0] dataBus;
  logic       nmi_n;
  logic       irq_n;
  logic [7:0] statusReg;
  logic [7:0] opcode;
  logic [3:0] interruptArray;
  logic       intActive;
  logic       noIncPC;

  modport master (
    output RDY, T1now, dataBus, nmi_n, irq_n, statusReg,
    input  opcode, interruptArray, intActive, noIncPC
  );

  modport slave (
    input  RDY, T1now, dataBus, nmi_n, irq_n, statusReg,
    output opcode, interruptArray, intActive, noIncPC
  );
endinterface

// File: rtl/predecode_int_ctrl.sv
// Opcode predecode with interrupt arbitration: at each T1 capture selects RST > NMI > IRQ > fetched opcode.
// NMI is edge-latched continuously; IRQ is level-sampled only at the capture edge.
module predecode_int_ctrl (
  input  logic                  phi2,
  input  logic                  rst,
  predecode_int_ctrl_if.slave   bus
);

  logic       nmi_prev_q;
  logic       nmi_arm_q;
  logic       nmi_pend_q;
  logic       nmi_pend_d;
  logic       rst_pend_q;
  logic [7:0] opcode_q;
  logic [3:0] int_arr_q;
  logic       int_act_q;

  logic       capture;
  logic       nmi_fall;
  logic       irq_req;
  logic       take_nmi;

  // nmi_arm_q blocks the first edge after reset release, so a pin already low at release
  // is not mistaken for a 1->0 transition against the forced-high nmi_prev_q.
  always_comb begin
    capture    = bus.RDY & bus.T1now;
    nmi_fall   = nmi_arm_q & nmi_prev_q & ~bus.nmi_n;
    irq_req    = ~bus.irq_n & ~bus.statusReg[2];
    take_nmi   = capture & ~rst_pend_q & nmi_pend_q;
    nmi_pend_d = nmi_fall | (nmi_pend_q & ~take_nmi);
  end

  always_ff @(posedge phi2 or negedge rst) begin
    if (!rst) begin
      nmi_prev_q <= 1'b1;
      nmi_arm_q  <= 1'b0;
      nmi_pend_q <= 1'b0;
      rst_pend_q <= 1'b1;
      opcode_q   <= 8'h00;
      int_arr_q  <= 4'b0001;
      int_act_q  <= 1'b1;
    end else begin
      nmi_prev_q <= bus.nmi_n;
      nmi_arm_q  <= 1'b1;
      nmi_pend_q <= nmi_pend_d;
      if (capture) begin
        if (rst_pend_q) begin
          opcode_q   <= 8'h00;
          int_arr_q  <= 4'b0001;
          int_act_q  <= 1'b1;
          rst_pend_q <= 1'b0;
        end else if (nmi_pend_q) begin
          opcode_q  <= 8'h00;
          int_arr_q <= 4'b0010;
          int_act_q <= 1'b1;
        end else if (irq_req) begin
          opcode_q  <= 8'h00;
          int_arr_q <= 4'b0100;
          int_act_q <= 1'b1;
        end else begin
          opcode_q  <= bus.dataBus;
          int_arr_q <= (bus.dataBus == 8'h00) ? 4'b1000 : 4'b0000;
          int_act_q <= 1'b0;
        end
      end
    end
  end

  assign bus.opcode         = opcode_q;
  assign bus.interruptArray = int_arr_q;
  assign bus.intActive      = int_act_q;
  assign bus.noIncPC        = int_act_q;

endmodule

// File: tb/tb_predecode_int_ctrl.sv
// Self-checking bench for predecode_int_ctrl: directed vector table, hand sequences for
// reset/NMI corner cases, and randomized stimulus against a behavioural model.
module tb_predecode_int_ctrl;

  typedef struct {
    logic       rdy;
    logic       t1;
    logic [7:0] data;
    logic       nmi_n;
    logic       irq_n;
    logic [7:0] st;
    logic [7:0] op;
    logic [3:0] ia;
    logic       act;
  } vec_t;

  logic phi2;
  logic rst;
  int   total;
  int   bad;

  predecode_int_ctrl_if bus ();

  predecode_int_ctrl dut (
    .phi2 (phi2),
    .rst  (rst),
    .bus  (bus.slave)
  );

  initial begin
    phi2 = 1'b0;
    forever #5 phi2 = ~phi2;
  end

  // Behavioural model: pending requests as flags, NMI request raised by an observed 1->0 pin change.
  bit         m_rst_req;
  bit         m_nmi_req;
  bit         m_pin_seen;
  logic       m_pin_last;
  logic [7:0] e_op;
  logic [3:0] e_ia;
  logic       e_act;

  function automatic vec_t mk(logic rdy, logic t1, logic [7:0] data, logic nmi_n, logic irq_n,
                              logic [7:0] st, logic [7:0] op, logic [3:0] ia, logic act);
    vec_t v;
    v.rdy = rdy; v.t1 = t1; v.data = data; v.nmi_n = nmi_n; v.irq_n = irq_n;
    v.st = st; v.op = op; v.ia = ia; v.act = act;
    return v;
  endfunction

  task automatic model_reset();
    m_rst_req  = 1'b1;
    m_nmi_req  = 1'b0;
    m_pin_seen = 1'b0;
    m_pin_last = 1'b1;
    e_op       = 8'h00;
    e_ia       = 4'b0001;
    e_act      = 1'b1;
  endtask

  task automatic model_edge();
    bit new_nmi;
    new_nmi = m_pin_seen && (m_pin_last == 1'b1) && (bus.nmi_n == 1'b0);
    if (bus.RDY && bus.T1now) begin
      if (m_rst_req) begin
        e_op = 8'h00; e_ia = 4'b0001; e_act = 1'b1; m_rst_req = 1'b0;
      end else if (m_nmi_req) begin
        e_op = 8'h00; e_ia = 4'b0010; e_act = 1'b1; m_nmi_req = 1'b0;
      end else if (!bus.irq_n && !bus.statusReg[2]) begin
        e_op = 8'h00; e_ia = 4'b0100; e_act = 1'b1;
      end else begin
        e_op  = bus.dataBus;
        e_ia  = (bus.dataBus == 8'h00) ? 4'b1000 : 4'b0000;
        e_act = 1'b0;
      end
    end
    if (new_nmi) m_nmi_req = 1'b1;
    m_pin_last = bus.nmi_n;
    m_pin_seen = 1'b1;
  endtask

  task automatic cmp(input string name, input logic [7:0] op, input logic [3:0] ia, input logic act);
    logic [13:0] got;
    logic [13:0] exp;
    got = {bus.opcode, bus.interruptArray, bus.intActive, bus.noIncPC};
    exp = {op, ia, act, act};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got op=%h ia=%b act=%b noinc=%b expected op=%h ia=%b act=%b noinc=%b",
               name, got[13:6], got[5:2], got[1], got[0], op, ia, act, act);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.RDY       = v.rdy;
    bus.T1now     = v.t1;
    bus.dataBus   = v.data;
    bus.nmi_n     = v.nmi_n;
    bus.irq_n     = v.irq_n;
    bus.statusReg = v.st;
  endtask

  task automatic run(input vec_t v, input string name);
    drive(v);
    model_edge();
    @(posedge phi2);
    #1;
    cmp(name, v.op, v.ia, v.act);
  endtask

  // Assert reset between clock edges and check the outputs before any edge arrives.
  task automatic do_reset(input logic nmi_level, input string name);
    bus.nmi_n = nmi_level;
    bus.irq_n = 1'b1;
    bus.RDY   = 1'b1;
    bus.T1now = 1'b0;
    rst = 1'b0;
    #1;
    cmp(name, 8'h00, 4'b0001, 1'b1);
    repeat (2) @(posedge phi2);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  vec_t vecs[$];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(mk(1, 0, 8'h00, 1, 1, 8'h00, 8'h00, 4'b0000, 0));
    model_reset();
    @(posedge phi2);
    #1;

    //              rdy t1 data   nmi irq st     op     ia       act
    vecs.push_back(mk(1, 1, 8'hA9, 1, 1, 8'h00, 8'h00, 4'b0001, 1));
    vecs.push_back(mk(1, 1, 8'hA9, 1, 1, 8'h00, 8'hA9, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 8'h33, 0, 1, 8'h00, 8'hA9, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 8'h33, 1, 1, 8'h00, 8'hA9, 4'b0000, 0));
    vecs.push_back(mk(1, 1, 8'hEA, 1, 1, 8'h00, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(1, 1, 8'hEA, 1, 1, 8'h00, 8'hEA, 4'b0000, 0));
    vecs.push_back(mk(1, 1, 8'h18, 1, 0, 8'h04, 8'h18, 4'b0000, 0));
    vecs.push_back(mk(1, 1, 8'h18, 1, 0, 8'h00, 8'h00, 4'b0100, 1));
    vecs.push_back(mk(1, 0, 8'h18, 0, 0, 8'h00, 8'h00, 4'b0100, 1));
    vecs.push_back(mk(1, 1, 8'h18, 0, 0, 8'h00, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(1, 1, 8'h18, 0, 0, 8'h00, 8'h00, 4'b0100, 1));
    vecs.push_back(mk(0, 1, 8'h55, 1, 1, 8'h00, 8'h00, 4'b0100, 1));
    vecs.push_back(mk(0, 1, 8'h55, 0, 1, 8'h00, 8'h00, 4'b0100, 1));
    vecs.push_back(mk(1, 1, 8'h55, 0, 1, 8'h00, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(1, 1, 8'h00, 1, 1, 8'h00, 8'h00, 4'b1000, 0));
    vecs.push_back(mk(1, 1, 8'h3C, 1, 1, 8'h00, 8'h3C, 4'b0000, 0));
    // NMI taken while a fresh falling edge arrives on the same capture: request survives
    vecs.push_back(mk(1, 0, 8'h11, 0, 1, 8'h00, 8'h3C, 4'b0000, 0));
    vecs.push_back(mk(1, 0, 8'h11, 1, 1, 8'h00, 8'h3C, 4'b0000, 0));
    vecs.push_back(mk(1, 1, 8'h11, 0, 1, 8'h00, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(1, 1, 8'h11, 0, 1, 8'h00, 8'h00, 4'b0010, 1));
    vecs.push_back(mk(1, 1, 8'h11, 1, 1, 8'h00, 8'h11, 4'b0000, 0));

    do_reset(1'b1, "reset_async");
    foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

    // RST and NMI both pending at the first capture: RST first, NMI next
    do_reset(1'b1, "reset_rst_nmi");
    run(mk(1, 0, 8'h77, 1, 1, 8'h00, 8'h00, 4'b0001, 1), "rstnmi_hold");
    run(mk(1, 0, 8'h77, 0, 1, 8'h00, 8'h00, 4'b0001, 1), "rstnmi_edge");
    run(mk(1, 1, 8'h77, 0, 1, 8'h00, 8'h00, 4'b0001, 1), "rstnmi_rst");
    run(mk(1, 1, 8'h77, 1, 1, 8'h00, 8'h00, 4'b0010, 1), "rstnmi_nmi");
    run(mk(1, 1, 8'h77, 1, 1, 8'h00, 8'h77, 4'b0000, 0), "rstnmi_op");

    // Pending NMI abandoned by a mid-instruction reset
    run(mk(1, 0, 8'h42, 0, 1, 8'h00, 8'h77, 4'b0000, 0), "abandon_edge");
    do_reset(1'b1, "reset_abandon");
    run(mk(1, 1, 8'h42, 1, 1, 8'h00, 8'h00, 4'b0001, 1), "abandon_rst");
    run(mk(1, 1, 8'h42, 1, 1, 8'h00, 8'h42, 4'b0000, 0), "abandon_op");

    // nmi_n held low through reset release is not an NMI
    do_reset(1'b0, "reset_nmi_low");
    run(mk(1, 1, 8'h69, 0, 1, 8'h00, 8'h00, 4'b0001, 1), "nmilow_rst");
    run(mk(1, 1, 8'h69, 0, 1, 8'h00, 8'h69, 4'b0000, 0), "nmilow_op");
    run(mk(1, 1, 8'h6A, 0, 1, 8'h00, 8'h6A, 4'b0000, 0), "nmilow_op2");

    // Randomized run against the model
    do_reset(1'b1, "reset_rand");
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      v.rdy   = ($urandom % 4) != 0;
      v.t1    = ($urandom % 3) == 0;
      v.data  = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
      v.nmi_n = (($urandom % 6) == 0) ? ~bus.nmi_n : bus.nmi_n;
      v.irq_n = ($urandom % 3) != 0;
      v.st    = 8'($urandom);
      drive(v);
      model_edge();
      @(posedge phi2);
      #1;
      cmp($sformatf("rand%0d", n), e_op, e_ia, e_act);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
